// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler sharing one bit-serial adder between two requesters.
// Define SERADD_CHECK_EN to add a reference-sum self-check that drives rsp_err.
module serial_add_sched #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_err,
    output logic             busy,
    output logic             add_pload,
    output logic             add_enable,
    output logic [WIDTH-1:0] add_adata,
    output logic [WIDTH-1:0] add_bdata,
    input  logic [WIDTH-1:0] add_pout
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, RESP} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          id;
    logic          grant0;
    logic          grant1;
    // On a tie the requester that did not win last time is served.
    assign grant0     = state == IDLE && req0_valid && (!req1_valid || last_grant);
    assign grant1     = state == IDLE && req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            id         <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            add_pload  <= 1'b0;
            add_enable <= 1'b0;
            add_adata  <= '0;
            add_bdata  <= '0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    add_adata  <= grant1 ? req1_a : req0_a;
                    add_bdata  <= grant1 ? req1_b : req0_b;
                    id         <= grant1;
                    last_grant <= grant1;
                    add_pload  <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: begin
                    add_pload  <= 1'b0;
                    add_enable <= 1'b1;
                    cnt        <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        add_enable <= 1'b0;
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_sum   <= add_pout;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SERADD_CHECK_EN
    logic [WIDTH-1:0] ref_sum;
    assign ref_sum = add_adata + add_bdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_err <= 1'b0;
        else if (grant0 || grant1) rsp_err <= 1'b0;
        else if (state == CAPTURE) rsp_err <= add_pout != ref_sum;
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: scoreboard bench for serial_add_sched with a behavioural bit-serial adder.
module tb_serial_add_sched;
    localparam int W = 8;
`ifdef SERADD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         err;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_err, busy, add_pload, add_enable;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_sum, add_adata, add_bdata, add_pout;
    logic         corrupt = 1'b0;

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    logic id_log[$];

    serial_add_sched #(.WIDTH(W), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_err(rsp_err), .busy(busy), .add_pload(add_pload), .add_enable(add_enable),
        .add_adata(add_adata), .add_bdata(add_bdata), .add_pout(add_pout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LSB-first serial adder: the sum shifts in from the top of sp.
    logic [W-1:0] sa, sb, sp;
    logic         sc;
    always @(posedge clk) begin
        if (add_pload) begin
            sa <= add_adata;
            sb <= add_bdata;
            sc <= 1'b0;
            sp <= '0;
        end else if (add_enable) begin
            sp <= {sa[0] ^ sb[0] ^ sc, sp[W-1:1]};
            sc <= (sa[0] & sb[0]) | (sc & (sa[0] ^ sb[0]));
            sa <= sa >> 1;
            sb <= sb >> 1;
        end
    end
    assign add_pout = corrupt ? '0 : sp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic         m_last = 1'b1, pv = 1'b0, ov = 1'b0, g;
    int           en_cnt = 0, pl_cnt = 0;
    logic [W-1:0] es;
    exp_t         e;
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            m_last = 1'b1;
            pv     = 1'b0;
            ov     = 1'b0;
            en_cnt = 0;
            pl_cnt = 0;
        end else begin
            if (add_enable) en_cnt++;
            if (add_pload) pl_cnt++;
            if (add_enable && add_pload) ov = 1'b1;
            if (req0_ready || req1_ready) begin
                g = (req0_valid && req1_valid) ? !m_last : req1_valid;
                chk("grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
                m_last = g;
                es = g ? req1_a + req1_b : req0_a + req0_b;
                sbq.push_back('{g, corrupt ? '0 : es, corrupt & CHK, cyc});
                en_cnt = 0;
                pl_cnt = 0;
                ov     = 1'b0;
            end
            if (rsp_valid && !pv) begin
                if (sbq.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    chk("latency", cyc - sbq[0].cyc, W + 3);
                    chk("enable_cycles", en_cnt, W);
                    chk("pload_cycles", pl_cnt, 1);
                    chk("pload_enable_overlap", ov, 0);
                end
            end
            if (rsp_valid && rsp_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_sum", rsp_sum, e.sum);
                chk("rsp_err", rsp_err, e.err);
                id_log.push_back(rsp_id);
            end
            pv = rsp_valid;
        end
    end

    task automatic issue(input bit r, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        if (r) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        do begin
            @(negedge clk);
            t++;
        end while (!(r ? req1_ready : req0_ready) && t < 100);
        chk("accept_timeout", r ? req1_ready : req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sbq.size() != 0 || rsp_valid) && t < 200);
        chk("drain", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input bit r, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(r, a, b);
        drain();
    endtask

    task automatic tie(input int n);
        int  got = 0;
        int  t = 0;
        bit  w0, w1;
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom);
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom);
        while (got < n && t < 400) begin
            @(negedge clk);
            t++;
            w0 = req0_ready;
            w1 = req1_ready;
            if (w0 || w1) got++;
            @(posedge clk);
            #1;
            if (got == n) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else if (w0) begin
                req0_a = W'($urandom); req0_b = W'($urandom);
            end else if (w1) begin
                req1_a = W'($urandom); req1_b = W'($urandom);
            end
        end
        chk("tie_accepts", got, n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_pload", add_pload, 0);
        chk("rst_enable", add_enable, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_adata", add_adata, 0);
        chk("rst_err", rsp_err, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        id_log.delete();
        tie(4);
        chk("tie_count", id_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("tie_order", i < id_log.size() ? 32'(id_log[i]) : 32'd2, i % 2);

        op(1'b0, 8'hAA, 8'h55);
        op(1'b1, 8'hFF, 8'h01);

        rsp_ready = 1'b0;
        issue(1'b0, 8'h12, 8'h34);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 50);
        chk("bp_rsp_timeout", rsp_valid, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 8'h30; req0_b = 8'h40;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_sum", rsp_sum, 8'h46);
            chk("bp_ready_low", req0_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake", rsp_valid, 1);
        chk("bp_ready_in_resp", req0_ready, 0);
        @(negedge clk);
        chk("bp_accept_after_hs", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        drain();

        issue(1'b0, 8'h5A, 8'h0F);
        k = 0;
        do begin
            @(negedge clk);
            if (add_enable) k++;
        end while (k < 3 && cyc < 5000);
        @(posedge clk);
        #1;
        chk("pre_rst_enable", add_enable, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_enable", add_enable, 0);
        chk("mid_rst_pload", add_pload, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        id_log.delete();
        tie(2);
        chk("post_rst_tie_count", id_log.size(), 2);
        for (int i = 0; i < 2; i++) chk("post_rst_tie_order", i < id_log.size() ? 32'(id_log[i]) : 32'd2, i % 2);
        op(1'b1, 8'h10, 8'h20);

        corrupt = 1'b1;
        op(1'b0, 8'h01, 8'h01);
        corrupt = 1'b0;
        op(1'b1, 8'h80, 8'h80);

        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
